// File: rtl/adc_channel_scheduler_pkg.sv
// Shared types and constants for the multiplexed ADC channel scheduler.
// Channel indices follow the analyzer's input order: phase voltages first, then currents.
package adc_channel_scheduler_pkg;

  localparam int DEF_NUM_CH = 6;
  localparam int DEF_CH_W   = 3;
  localparam int DEF_DATA_W = 8;

  localparam logic [DEF_CH_W-1:0] CH_VA = 3'd0;
  localparam logic [DEF_CH_W-1:0] CH_VB = 3'd1;
  localparam logic [DEF_CH_W-1:0] CH_VC = 3'd2;
  localparam logic [DEF_CH_W-1:0] CH_IA = 3'd3;
  localparam logic [DEF_CH_W-1:0] CH_IB = 3'd4;
  localparam logic [DEF_CH_W-1:0] CH_IC = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_STORE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/adc_channel_scheduler_if.sv
// Bus between the scheduler, the analog mux / ADC controller, and the sample consumer.
// master = scheduler side; slave = ADC controller and downstream consumer side.
interface adc_channel_scheduler_if
  import adc_channel_scheduler_pkg::*;
#(
  parameter int CH_W   = DEF_CH_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [CH_W-1:0]   mux_sel;
  logic              conv_start;
  logic              conv_done;
  logic [DATA_W-1:0] adc_data;
  logic              sample_valid;
  logic [CH_W-1:0]   sample_ch;
  logic [DATA_W-1:0] sample_data;
  logic              sample_err;
  logic              frame_done;

  modport master (
    output mux_sel, conv_start, sample_valid, sample_ch, sample_data, sample_err, frame_done,
    input  conv_done, adc_data
  );

  modport slave (
    input  mux_sel, conv_start, sample_valid, sample_ch, sample_data, sample_err, frame_done,
    output conv_done, adc_data
  );

endinterface

// File: rtl/adc_channel_scheduler_sample_tick_gen.sv
// Frame-rate tick generator: wrapping period counter, held at zero while disabled,
// so the first tick arrives a full period after enable rises.
module sample_tick_gen #(
  parameter int SAMPLE_PERIOD = 1667
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

  logic [PER_W-1:0] count_reg;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (!enable || (count_reg == PER_LAST)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + PER_W'(1);
    end
  end

  assign tick = enable && (count_reg == PER_LAST);

endmodule

// File: rtl/adc_channel_scheduler.sv
// Sequences one serial ADC over NUM_CH mux inputs per frame tick: select, settle,
// convert (with timeout), then emit a tagged sample; flags overruns and timeouts.
module adc_channel_scheduler
  import adc_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int CH_W          = DEF_CH_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SAMPLE_PERIOD = 1667,
  parameter int SETTLE_CYCLES = 83,
  parameter int CONV_TIMEOUT  = 1000
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            enable,
  adc_channel_scheduler_if.master         bus,
  output logic                            busy,
  output logic                            overrun,
  output logic                            timeout_err
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W    = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;
  localparam logic [CH_W-1:0]     LAST_CH     = CH_W'(NUM_CH - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(CONV_TIMEOUT - 1);

  logic tick;

  sample_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick_gen (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  sched_state_t      state_reg,        state_next;
  logic [CH_W-1:0]   ch_reg,           ch_next;
  logic [CH_W-1:0]   mux_sel_reg,      mux_sel_next;
  logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [TMO_W-1:0]  timeout_cnt_reg,  timeout_cnt_next;
  logic              conv_start_reg,   conv_start_next;
  logic              sample_valid_reg, sample_valid_next;
  logic [CH_W-1:0]   sample_ch_reg,    sample_ch_next;
  logic [DATA_W-1:0] sample_data_reg,  sample_data_next;
  logic              sample_err_reg,   sample_err_next;
  logic              frame_done_reg,   frame_done_next;
  logic              overrun_reg,      overrun_next;
  logic              timeout_err_reg,  timeout_err_next;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      ch_reg           <= '0;
      mux_sel_reg      <= '0;
      settle_cnt_reg   <= '0;
      timeout_cnt_reg  <= '0;
      conv_start_reg   <= 1'b0;
      sample_valid_reg <= 1'b0;
      sample_ch_reg    <= '0;
      sample_data_reg  <= '0;
      sample_err_reg   <= 1'b0;
      frame_done_reg   <= 1'b0;
      overrun_reg      <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ch_reg           <= ch_next;
      mux_sel_reg      <= mux_sel_next;
      settle_cnt_reg   <= settle_cnt_next;
      timeout_cnt_reg  <= timeout_cnt_next;
      conv_start_reg   <= conv_start_next;
      sample_valid_reg <= sample_valid_next;
      sample_ch_reg    <= sample_ch_next;
      sample_data_reg  <= sample_data_next;
      sample_err_reg   <= sample_err_next;
      frame_done_reg   <= frame_done_next;
      overrun_reg      <= overrun_next;
      timeout_err_reg  <= timeout_err_next;
    end
  end

  // Sample outputs are registered at the CONVERT->STORE transition so that
  // sample_valid/frame_done are high exactly during the STORE cycle.
  always_comb begin
    state_next        = state_reg;
    ch_next           = ch_reg;
    mux_sel_next      = mux_sel_reg;
    settle_cnt_next   = settle_cnt_reg;
    timeout_cnt_next  = timeout_cnt_reg;
    conv_start_next   = 1'b0;
    sample_valid_next = 1'b0;
    sample_ch_next    = sample_ch_reg;
    sample_data_next  = sample_data_reg;
    sample_err_next   = sample_err_reg;
    frame_done_next   = 1'b0;
    overrun_next      = overrun_reg || (tick && (state_reg != ST_IDLE));
    timeout_err_next  = timeout_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (tick) begin
          ch_next         = '0;
          mux_sel_next    = '0;
          settle_cnt_next = SETTLE_LOAD;
          state_next      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        timeout_cnt_next = '0;
        if (settle_cnt_reg == '0) begin
          conv_start_next = 1'b1;
          state_next      = ST_CONVERT;
        end else begin
          settle_cnt_next = settle_cnt_reg - SETTLE_W'(1);
        end
      end

      ST_CONVERT: begin
        if (bus.conv_done) begin
          sample_valid_next = 1'b1;
          sample_ch_next    = ch_reg;
          sample_data_next  = bus.adc_data;
          sample_err_next   = 1'b0;
          frame_done_next   = (ch_reg == LAST_CH);
          state_next        = ST_STORE;
        end else if (timeout_cnt_reg == TMO_LAST) begin
          sample_valid_next = 1'b1;
          sample_ch_next    = ch_reg;
          sample_data_next  = '0;
          sample_err_next   = 1'b1;
          frame_done_next   = (ch_reg == LAST_CH);
          timeout_err_next  = 1'b1;
          state_next        = ST_STORE;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + TMO_W'(1);
        end
      end

      ST_STORE: begin
        if (ch_reg == LAST_CH) begin
          state_next = ST_IDLE;
        end else begin
          ch_next         = ch_reg + CH_W'(1);
          mux_sel_next    = ch_reg + CH_W'(1);
          settle_cnt_next = SETTLE_LOAD;
          state_next      = ST_SETTLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.mux_sel      = mux_sel_reg;
  assign bus.conv_start   = conv_start_reg;
  assign bus.sample_valid = sample_valid_reg;
  assign bus.sample_ch    = sample_ch_reg;
  assign bus.sample_data  = sample_data_reg;
  assign bus.sample_err   = sample_err_reg;
  assign bus.frame_done   = frame_done_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign overrun          = overrun_reg;
  assign timeout_err      = timeout_err_reg;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench: instance A (period 200) covers frames, timeouts and control;
// instance B (period 60) covers frame overrun.
`timescale 1ns/1ps
module tb_adc_channel_scheduler;
  import adc_channel_scheduler_pkg::*;

  localparam int NUM_CH = 6;
  localparam int CH_W   = 3;
  localparam int DATA_W = 8;
  localparam int SETTLE = 4;
  localparam int TMO    = 20;
  localparam int DLY    = 10;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic reset;
  logic en_a, en_b;
  logic busy_a, ovr_a, toe_a;
  logic busy_b, ovr_b, toe_b;

  adc_channel_scheduler_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus_a ();
  adc_channel_scheduler_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus_b ();

  adc_channel_scheduler #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W),
    .SAMPLE_PERIOD(200), .SETTLE_CYCLES(SETTLE), .CONV_TIMEOUT(TMO)
  ) u_a (
    .clk_in(clk_in), .reset(reset), .enable(en_a), .bus(bus_a),
    .busy(busy_a), .overrun(ovr_a), .timeout_err(toe_a)
  );

  adc_channel_scheduler #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W),
    .SAMPLE_PERIOD(60), .SETTLE_CYCLES(SETTLE), .CONV_TIMEOUT(TMO)
  ) u_b (
    .clk_in(clk_in), .reset(reset), .enable(en_b), .bus(bus_b),
    .busy(busy_b), .overrun(ovr_b), .timeout_err(toe_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // ADC models: per-channel response delay after conv_start; 0 means never respond.
  int dly_a[NUM_CH];
  int pend_a = 0, pend_ch_a = 0;
  int pend_b = 0, pend_ch_b = 0;

  initial begin
    bus_a.conv_done = 1'b0;
    bus_a.adc_data  = '0;
    forever begin
      @(posedge clk_in); #1;
      bus_a.conv_done = 1'b0;
      if (pend_a > 0) begin
        pend_a--;
        if (pend_a == 0) begin
          bus_a.conv_done = 1'b1;
          bus_a.adc_data  = 8'(16 + pend_ch_a);
        end
      end
      if (bus_a.conv_start) begin
        pend_ch_a = int'(bus_a.mux_sel);
        pend_a    = dly_a[pend_ch_a];
      end
    end
  end

  initial begin
    bus_b.conv_done = 1'b0;
    bus_b.adc_data  = '0;
    forever begin
      @(posedge clk_in); #1;
      bus_b.conv_done = 1'b0;
      if (pend_b > 0) begin
        pend_b--;
        if (pend_b == 0) begin
          bus_b.conv_done = 1'b1;
          bus_b.adc_data  = 8'(16 + pend_ch_b);
        end
      end
      if (bus_b.conv_start) begin
        pend_ch_b = int'(bus_b.mux_sel);
        pend_b    = DLY;
      end
    end
  end

  // Observers: record samples, frame starts and mux-to-conv_start gaps.
  int q_ch_a[$], q_data_a[$], q_err_a[$], q_fd_a[$], q_gap_a[$], q_start_a[$];
  int q_ch_b[$], q_start_b[$];
  int fd_cnt_a = 0, st_cnt_a = 0, sv_cnt_a = 0, fd_cnt_b = 0, st_cnt_b = 0;
  int mux_t_a = 0;
  logic busy_prev_a = 1'b0, busy_prev_b = 1'b0;
  logic [CH_W-1:0] mux_prev_a = '0;

  initial begin
    forever begin
      @(posedge clk_in); #1;
      if (busy_a && !busy_prev_a) begin
        q_start_a.push_back(cyc);
        st_cnt_a++;
        mux_t_a = cyc;
      end else if (bus_a.mux_sel != mux_prev_a) begin
        mux_t_a = cyc;
      end
      if (bus_a.conv_start) q_gap_a.push_back(cyc - mux_t_a);
      if (bus_a.sample_valid) begin
        q_ch_a.push_back(int'(bus_a.sample_ch));
        q_data_a.push_back(int'(bus_a.sample_data));
        q_err_a.push_back(int'(bus_a.sample_err));
        q_fd_a.push_back(int'(bus_a.frame_done));
        sv_cnt_a++;
      end
      if (bus_a.frame_done) fd_cnt_a++;
      busy_prev_a = busy_a;
      mux_prev_a  = bus_a.mux_sel;

      if (busy_b && !busy_prev_b) begin
        q_start_b.push_back(cyc);
        st_cnt_b++;
      end
      if (bus_b.sample_valid) q_ch_b.push_back(int'(bus_b.sample_ch));
      if (bus_b.frame_done) fd_cnt_b++;
      busy_prev_b = busy_b;
    end
  end

  function automatic logic [20:0] outs_a();
    return {bus_a.mux_sel, bus_a.conv_start, bus_a.sample_valid, bus_a.sample_ch,
            bus_a.sample_data, bus_a.sample_err, bus_a.frame_done, busy_a, ovr_a, toe_a};
  endfunction

  function automatic logic [20:0] outs_b();
    return {bus_b.mux_sel, bus_b.conv_start, bus_b.sample_valid, bus_b.sample_ch,
            bus_b.sample_data, bus_b.sample_err, bus_b.frame_done, busy_b, ovr_b, toe_b};
  endfunction

  function automatic int evt_count(input int which);
    case (which)
      0:       return fd_cnt_a;
      1:       return st_cnt_a;
      2:       return fd_cnt_b;
      default: return st_cnt_b;
    endcase
  endfunction

  // Bounded wait on an observer counter; an expired bound counts as a failure.
  task automatic wait_evt(input int which, input int target, input int bound, input string name);
    int i;
    i = 0;
    while ((evt_count(which) < target) && (i < bound)) begin
      @(posedge clk_in); #2;
      i++;
    end
    checks++;
    if (evt_count(which) < target) begin
      errors++;
      $display("FAIL %s: event count %0d, required %0d within %0d cycles",
               name, evt_count(which), target, bound);
    end
  endtask

  task automatic clear_a();
    q_ch_a.delete(); q_data_a.delete(); q_err_a.delete();
    q_fd_a.delete(); q_gap_a.delete(); q_start_a.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0;
    for (int i = 0; i < NUM_CH; i++) dly_a[i] = DLY;
    repeat (3) @(posedge clk_in);
    #2;
    checks++;
    if (outs_a() !== '0) begin
      errors++; $display("FAIL reset_outs_a: got %h, required 0", outs_a());
    end
    checks++;
    if (outs_b() !== '0) begin
      errors++; $display("FAIL reset_outs_b: got %h, required 0", outs_b());
    end
    @(posedge clk_in); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk_in);
    #2;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL idle_when_disabled: busy %0b, required 0", busy_a);
    end
    $display("test_reset done");
  endtask

  task automatic test_normal_frame();
    int t_en;
    clear_a();
    @(posedge clk_in); #1;
    en_a = 1'b1;
    t_en = cyc;
    wait_evt(0, fd_cnt_a + 1, 400, "normal_frame_done");
    checks++;
    if (q_start_a.size() < 1 || q_start_a[0] - t_en !== 200) begin
      errors++; $display("FAIL first_tick_delay: got %0d, required 200",
                         (q_start_a.size() > 0) ? q_start_a[0] - t_en : -1);
    end
    checks++;
    if (q_ch_a.size() !== NUM_CH) begin
      errors++; $display("FAIL normal_sample_count: got %0d, required %0d", q_ch_a.size(), NUM_CH);
    end
    for (int i = 0; i < NUM_CH && i < q_ch_a.size(); i++) begin
      checks++;
      if (q_ch_a[i] !== i || q_data_a[i] !== 16 + i || q_err_a[i] !== 0
          || q_fd_a[i] !== ((i == int'(CH_IC)) ? 1 : 0)) begin
        errors++;
        $display("FAIL normal_sample_%0d: ch %0d data %h err %0d fd %0d, required ch %0d data %h err 0 fd %0d",
                 i, q_ch_a[i], q_data_a[i], q_err_a[i], q_fd_a[i], i, 16 + i, (i == NUM_CH - 1) ? 1 : 0);
      end
      $display("sample ch=%0d data=%h err=%0d fd=%0d", q_ch_a[i], q_data_a[i], q_err_a[i], q_fd_a[i]);
    end
    checks++;
    if (q_gap_a.size() !== NUM_CH) begin
      errors++; $display("FAIL conv_start_count: got %0d, required %0d", q_gap_a.size(), NUM_CH);
    end
    for (int i = 0; i < q_gap_a.size(); i++) begin
      checks++;
      if (q_gap_a[i] !== SETTLE) begin
        errors++; $display("FAIL settle_gap_%0d: got %0d cycles, required %0d", i, q_gap_a[i], SETTLE);
      end
    end
  endtask

  task automatic test_periodicity();
    wait_evt(0, fd_cnt_a + 2, 600, "periodic_frames");
    checks++;
    if (q_start_a.size() < 3 || q_start_a[1] - q_start_a[0] !== 200 || q_start_a[2] - q_start_a[1] !== 200) begin
      errors++; $display("FAIL frame_period: starts seen %0d, gaps %0d/%0d, required 200/200", q_start_a.size(),
                         (q_start_a.size() > 1) ? q_start_a[1] - q_start_a[0] : -1,
                         (q_start_a.size() > 2) ? q_start_a[2] - q_start_a[1] : -1);
    end
    checks++;
    if (ovr_a !== 1'b0) begin
      errors++; $display("FAIL periodic_overrun: got %0b, required 0", ovr_a);
    end
    $display("periodicity: %0d frames observed", q_start_a.size());
  endtask

  task automatic test_boundary();
    dly_a[CH_IA] = TMO - 1;
    clear_a();
    wait_evt(0, fd_cnt_a + 1, 400, "boundary_frame");
    checks++;
    if (q_ch_a.size() !== NUM_CH || q_data_a[3] !== 16 + 3 || q_err_a[3] !== 0) begin
      errors++; $display("FAIL boundary_sample: count %0d data %h err %0d, required 6 / 13 / 0",
                         q_ch_a.size(), q_data_a[3], q_err_a[3]);
    end
    checks++;
    if (toe_a !== 1'b0) begin
      errors++; $display("FAIL boundary_timeout_err: got %0b, required 0", toe_a);
    end
    $display("boundary: ch3 data=%h err=%0d timeout_err=%0b", q_data_a[3], q_err_a[3], toe_a);
    dly_a[CH_IA] = DLY;
  endtask

  task automatic test_timeout();
    dly_a[CH_VC] = 0;
    clear_a();
    wait_evt(0, fd_cnt_a + 1, 400, "timeout_frame");
    checks++;
    if (q_ch_a.size() !== NUM_CH || q_ch_a[2] !== 2 || q_data_a[2] !== 0 || q_err_a[2] !== 1) begin
      errors++; $display("FAIL timeout_sample: count %0d ch %0d data %h err %0d, required 6 / 2 / 0 / 1",
                         q_ch_a.size(), q_ch_a[2], q_data_a[2], q_err_a[2]);
    end
    for (int i = 3; i < NUM_CH && i < q_ch_a.size(); i++) begin
      checks++;
      if (q_ch_a[i] !== i || q_data_a[i] !== 16 + i || q_err_a[i] !== 0) begin
        errors++; $display("FAIL after_timeout_%0d: ch %0d data %h err %0d, required ch %0d data %h err 0",
                           i, q_ch_a[i], q_data_a[i], q_err_a[i], i, 16 + i);
      end
    end
    checks++;
    if (toe_a !== 1'b1) begin
      errors++; $display("FAIL timeout_err_sticky: got %0b, required 1", toe_a);
    end
    $display("timeout: ch2 data=%h err=%0d timeout_err=%0b", q_data_a[2], q_err_a[2], toe_a);
    dly_a[CH_VC] = DLY;
  endtask

  task automatic test_overrun();
    q_ch_b.delete(); q_start_b.delete();
    @(posedge clk_in); #1;
    en_b = 1'b1;
    wait_evt(3, st_cnt_b + 1, 100, "overrun_first_start");
    checks++;
    if (ovr_b !== 1'b0) begin
      errors++; $display("FAIL overrun_before_2nd_tick: got %0b, required 0", ovr_b);
    end
    wait_evt(2, fd_cnt_b + 1, 200, "overrun_frame_done");
    checks++;
    if (ovr_b !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %0b, required 1", ovr_b);
    end
    checks++;
    if (q_ch_b.size() !== NUM_CH || q_start_b.size() !== 1) begin
      errors++; $display("FAIL overrun_frame_intact: samples %0d starts %0d, required 6 / 1",
                         q_ch_b.size(), q_start_b.size());
    end
    for (int i = 0; i < q_ch_b.size(); i++) begin
      checks++;
      if (q_ch_b[i] !== i) begin
        errors++; $display("FAIL overrun_order_%0d: ch %0d, required %0d", i, q_ch_b[i], i);
      end
    end
    en_b = 1'b0;
    $display("overrun: overrun=%0b samples=%0d", ovr_b, q_ch_b.size());
  endtask

  task automatic test_control();
    int n, sv0, st0, t_rel, t_en;
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      @(posedge clk_in); #2;
      if (bus_a.conv_start && bus_a.mux_sel == CH_IA) found = 1'b1;
      n++;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL find_convert_ch3: got 0, required 1");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (outs_a() !== '0) begin
      errors++; $display("FAIL async_reset_outs: got %h, required 0", outs_a());
    end
    @(posedge clk_in); #1;
    reset = 1'b0;
    t_rel = cyc;
    sv0 = sv_cnt_a;
    st0 = st_cnt_a;
    repeat (190) @(posedge clk_in);
    #2;
    checks++;
    if (sv_cnt_a !== sv0 || st_cnt_a !== st0) begin
      errors++; $display("FAIL no_output_after_reset: samples %0d starts %0d, required 0 / 0",
                         sv_cnt_a - sv0, st_cnt_a - st0);
    end
    q_start_a.delete();
    wait_evt(1, st0 + 1, 30, "restart_after_reset");
    checks++;
    if (q_start_a.size() < 1 || q_start_a[0] - t_rel !== 200) begin
      errors++; $display("FAIL tick_after_reset: got %0d, required 200",
                         (q_start_a.size() > 0) ? q_start_a[0] - t_rel : -1);
    end
    wait_evt(0, fd_cnt_a + 1, 200, "frame_after_reset");
    en_a = 1'b0;
    repeat (50) @(posedge clk_in);
    #1;
    q_start_a.delete();
    st0 = st_cnt_a;
    en_a = 1'b1;
    t_en = cyc;
    wait_evt(1, st0 + 1, 250, "restart_after_enable");
    checks++;
    if (q_start_a.size() < 1 || q_start_a[0] - t_en !== 200) begin
      errors++; $display("FAIL tick_after_enable: got %0d, required 200",
                         (q_start_a.size() > 0) ? q_start_a[0] - t_en : -1);
    end
    $display("control: reset and re-enable sequence complete");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal_frame();
    test_periodicity();
    test_boundary();
    test_timeout();
    test_overrun();
    test_control();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
